apple_spawner: RTL and testbench

//  Food side of the Snake game: the counterpart that consumes headX/headY from Snake and produces its addLength.

---
 rtl/apple_spawner.sv | 161 ++++++++++++++++
 tb/tb_apple_spawner.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apple_spawner.sv
// Apple placement and eat detection for the Snake game, plus the registered apple pixel for the VGA mixer.
// Optional build macro APPLE_ROUND_EN blanks the four corner pixels of the apple cell.
`timescale 1ns/1ps

module apple_spawner #(
    parameter int          GRID_W     = 40,
    parameter int          GRID_H     = 30,
    parameter int          CELL_SHIFT = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          RETRY_MAX  = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gameStatus,
    input  logic [5:0] headX,
    input  logic [5:0] headY,
    input  logic [9:0] xPos,
    input  logic [9:0] yPos,
    output logic       addLength,
    output logic [5:0] appleX,
    output logic [5:0] appleY,
    output logic       appleValid,
    output logic       apple,
    output logic [6:0] eatenCount
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SPAWN = 2'd1;
    localparam logic [1:0] S_ARMED = 2'd2;
    localparam logic [1:0] PLAY    = 2'b10;

    localparam int         RW        = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    localparam logic [5:0] X_MAX = 6'(GRID_W - 2);
    localparam logic [5:0] Y_MAX = 6'(GRID_H - 2);
    localparam logic [5:0] FB_X  = 6'(GRID_W / 2);
    localparam logic [5:0] FB_X1 = 6'(GRID_W / 2 + 1);
    localparam logic [5:0] FB_Y  = 6'(GRID_H / 2);

    logic [1:0]    r_state;
    logic [15:0]   r_lfsr;
    logic [RW-1:0] r_retry;
    logic [5:0]    r_apple_x, r_apple_y;
    logic          r_valid, r_add, r_apple;
    logic [6:0]    r_eaten;

    logic [1:0]    w_state_nx;
    logic [15:0]   w_lfsr_nx;
    logic [RW-1:0] w_retry_nx;
    logic [5:0]    w_x_nx, w_y_nx, w_cx, w_cy, w_fb_x, w_px, w_py;
    logic          w_valid_nx, w_add_nx, w_apple_nx;
    logic [6:0]    w_eaten_nx;
    logic          w_play, w_accept, w_head_hit, w_cell_hit, w_corner;

    assign w_lfsr_nx  = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
    assign w_cx       = r_lfsr[5:0];
    assign w_cy       = r_lfsr[11:6];
    assign w_play     = (gameStatus == PLAY);
    assign w_accept   = (w_cx >= 6'd1) && (w_cx <= X_MAX) && (w_cy >= 6'd1) && (w_cy <= Y_MAX)
                        && !((w_cx == headX) && (w_cy == headY));
    assign w_head_hit = (headX == r_apple_x) && (headY == r_apple_y);
    // The fallback shifts right by one when the head already sits on the centre cell.
    assign w_fb_x     = ((headX == FB_X) && (headY == FB_Y)) ? FB_X1 : FB_X;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nx = r_state;
        w_valid_nx = r_valid;
        w_x_nx     = r_apple_x;
        w_y_nx     = r_apple_y;
        w_retry_nx = r_retry;
        w_eaten_nx = r_eaten;
        w_add_nx   = 1'b0;
        if (!w_play) begin
            w_state_nx = S_IDLE;
            w_valid_nx = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_valid_nx = 1'b0;
                    w_eaten_nx = 7'd0;
                    w_retry_nx = '0;
                    w_state_nx = S_SPAWN;
                end
                S_SPAWN: begin
                    if (r_retry == RETRY_LIM) begin
                        w_x_nx     = w_fb_x;
                        w_y_nx     = FB_Y;
                        w_valid_nx = 1'b1;
                        w_state_nx = S_ARMED;
                    end else if (w_accept) begin
                        w_x_nx     = w_cx;
                        w_y_nx     = w_cy;
                        w_valid_nx = 1'b1;
                        w_state_nx = S_ARMED;
                    end else begin
                        w_retry_nx = r_retry + RW'(1);
                    end
                end
                S_ARMED: begin
                    if (w_head_hit) begin
                        w_add_nx   = 1'b1;
                        w_eaten_nx = (r_eaten == 7'd127) ? r_eaten : r_eaten + 7'd1;
                        w_valid_nx = 1'b0;
                        w_retry_nx = '0;
                        w_state_nx = S_SPAWN;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_valid_nx = 1'b0;
                end
            endcase
        end
    end

    assign w_px       = 6'(xPos >> CELL_SHIFT);
    assign w_py       = 6'(yPos >> CELL_SHIFT);
    assign w_cell_hit = (w_px == r_apple_x) && (w_py == r_apple_y);
`ifdef APPLE_ROUND_EN
    assign w_corner = ((~|xPos[CELL_SHIFT-1:0]) || (&xPos[CELL_SHIFT-1:0]))
                      && ((~|yPos[CELL_SHIFT-1:0]) || (&yPos[CELL_SHIFT-1:0]));
`else
    assign w_corner = 1'b0;
`endif
    // Gating with the next valid keeps the pixel dark on the same cycle appleValid drops.
    assign w_apple_nx = r_valid && w_valid_nx && w_cell_hit && !w_corner;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lfsr    <= LFSR_SEED;
            r_retry   <= '0;
            r_apple_x <= 6'd0;
            r_apple_y <= 6'd0;
            r_valid   <= 1'b0;
            r_add     <= 1'b0;
            r_apple   <= 1'b0;
            r_eaten   <= 7'd0;
        end else begin
            r_state   <= w_state_nx;
            r_lfsr    <= w_lfsr_nx;
            r_retry   <= w_retry_nx;
            r_apple_x <= w_x_nx;
            r_apple_y <= w_y_nx;
            r_valid   <= w_valid_nx;
            r_add     <= w_add_nx;
            r_apple   <= w_apple_nx;
            r_eaten   <= w_eaten_nx;
        end
    end

    assign addLength  = r_add;
    assign appleX     = r_apple_x;
    assign appleY     = r_apple_y;
    assign appleValid = r_valid;
    assign apple      = r_apple;
    assign eatenCount = r_eaten;

endmodule

// File: tb/tb_apple_spawner.sv
// Scoreboard bench for apple_spawner: stimulus queues expected apples and pulses, a monitor compares them.
// Three instances: default, immediate-fallback (RETRY_MAX=0) and a seed that lands the apple on (5,7).
`timescale 1ns/1ps

module tb_apple_spawner;

    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          RMAX    = 31;
`ifdef APPLE_ROUND_EN
    localparam logic        ROUND   = 1'b1;
`else
    localparam logic        ROUND   = 1'b0;
`endif

    typedef struct {logic [5:0] x; logic [5:0] y;} pos_t;
    typedef struct {logic [6:0] eaten; int unsigned cyc;} pulse_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] game;
    logic [5:0] hx, hy, fhx, fhy, phx, phy;
    logic [9:0] xp, yp;

    logic       add, av, ap;
    logic [5:0] ax, ay;
    logic [6:0] ec;
    logic       f_add, f_av, f_ap;
    logic [5:0] f_ax, f_ay;
    logic [6:0] f_ec;
    logic       p_add, p_av, p_ap;
    logic [5:0] p_ax, p_ay;
    logic [6:0] p_ec;

    apple_spawner dut (
        .clk(clk), .rst(rst), .gameStatus(game), .headX(hx), .headY(hy),
        .xPos(xp), .yPos(yp), .addLength(add), .appleX(ax), .appleY(ay),
        .appleValid(av), .apple(ap), .eatenCount(ec)
    );

    apple_spawner #(.RETRY_MAX(0), .LFSR_SEED(16'h0080)) dut_fb (
        .clk(clk), .rst(rst), .gameStatus(game), .headX(fhx), .headY(fhy),
        .xPos(xp), .yPos(yp), .addLength(f_add), .appleX(f_ax), .appleY(f_ay),
        .appleValid(f_av), .apple(f_ap), .eatenCount(f_ec)
    );

    apple_spawner #(.LFSR_SEED(16'h038A)) dut_px (
        .clk(clk), .rst(rst), .gameStatus(game), .headX(phx), .headY(phy),
        .xPos(xp), .yPos(yp), .addLength(p_add), .appleX(p_ax), .appleY(p_ay),
        .appleValid(p_av), .apple(p_ap), .eatenCount(p_ec)
    );

    int total = 0;
    int bad   = 0;
    int unsigned cyc;
    pos_t   q_apple[$];
    pulse_t q_pulse[$];

    // Clock edges since reset release; the DUT LFSR has stepped exactly this many times.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Spawn entered on edge m evaluates step^m(seed) first, one candidate per cycle.
    function automatic pos_t predict(input logic [15:0] seed, input int rmax, input int unsigned m,
                                     input logic [5:0] hx_i, input logic [5:0] hy_i);
        logic [15:0] v;
        logic [5:0]  cx, cy;
        pos_t        p;
        v = seed;
        for (int i = 0; i < int'(m); i++) v = step(v);
        for (int k = 0; k < rmax; k++) begin
            cx = v[5:0];
            cy = v[11:6];
            if (cx >= 1 && cx <= 38 && cy >= 1 && cy <= 28 && !(cx == hx_i && cy == hy_i)) begin
                p.x = cx;
                p.y = cy;
                return p;
            end
            v = step(v);
        end
        p.x = (hx_i == 6'd20 && hy_i == 6'd15) ? 6'd21 : 6'd20;
        p.y = 6'd15;
        return p;
    endfunction

    initial begin : monitor
        logic   prev_v;
        pos_t   p;
        pulse_t pl;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (av && !prev_v) begin
                if (q_apple.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_apple: got (%0d,%0d), want none", ax, ay);
                end else begin
                    p = q_apple.pop_front();
                    check("apple_x", ax, p.x);
                    check("apple_y", ay, p.y);
                end
            end
            if (add) begin
                if (q_pulse.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got pulse at cycle %0d, want none", cyc);
                end else begin
                    pl = q_pulse.pop_front();
                    check("pulse_cycle", cyc, pl.cyc);
                    check("pulse_eaten", ec, pl.eaten);
                end
            end
            prev_v = av;
        end
    end

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (av) break;
        end
        check("valid_within_budget", av, 1);
    endtask

    task automatic push_spawn();
        q_apple.push_back(predict(SEED, RMAX, cyc + 1, hx, hy));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    int px_x [6] = '{88, 80, 96, 95, 80, 87};
    int px_y [6] = '{120, 112, 120, 127, 120, 111};
    logic px_e [6];

    initial begin : stim
        logic [5:0] ox, oy;
        px_e = '{1'b1, !ROUND, 1'b0, !ROUND, 1'b1, 1'b0};
        rst = 1'b1; game = 2'b10;
        hx = 6'd20; hy = 6'd15; fhx = 6'd20; fhy = 6'd15; phx = 6'd20; phy = 6'd15;
        xp = '0; yp = '0;

        // reset held with PLAY requested: everything stays zero
        repeat (3) begin
            @(negedge clk);
            check("reset_outs", {add, av, ap, ax, ay, ec}, 0);
            check("reset_outs_fb", {f_add, f_av, f_ap, f_ax, f_ay, f_ec}, 0);
        end

        push_spawn();
        rst = 1'b0;
        wait_valid(RMAX + 3);
        check("x_in_range", (ax >= 1 && ax <= 38), 1);
        check("y_in_range", (ay >= 1 && ay <= 28), 1);
        check("not_on_head", (ax == hx && ay == hy), 0);

        // fallback with head on centre cell goes one cell right
        check("fb_valid", f_av, 1);
        check("fb_pos_shift", {f_ax, f_ay}, {6'd21, 6'd15});

        // pixel vectors against the apple at (5,7)
        check("px_apple_pos", {p_av, p_ax, p_ay}, {1'b1, 6'd5, 6'd7});
        for (int i = 0; i < 6; i++) begin
            xp = 10'(px_x[i]);
            yp = 10'(px_y[i]);
            @(negedge clk);
            check($sformatf("pixel_%0d_%0d", px_x[i], px_y[i]), p_ap, px_e[i]);
        end

        // fallback instance: eat, then spawn with head away from centre
        fhx = 6'd21; fhy = 6'd15;
        @(negedge clk);
        check("fb_pulse", f_add, 1);
        fhx = 6'd1; fhy = 6'd1;
        @(negedge clk);
        check("fb_pulse_one_cycle", f_add, 0);
        check("fb_pos_centre", {f_av, f_ax, f_ay}, {1'b1, 6'd20, 6'd15});

        // head rests on the apple for 10 cycles: exactly one pulse
        ox = ax; oy = ay;
        hx = ox; hy = oy;
        q_pulse.push_back('{7'd1, cyc + 1});
        push_spawn();
        repeat (10) @(negedge clk);
        wait_valid(RMAX + 3);
        check("eaten_one", ec, 1);
        check("new_not_head", (ax == hx && ay == hy), 0);

        // leave PLAY in ARMED with head on apple: no pulse, count held
        hx = ax; hy = ay; game = 2'b00;
        @(negedge clk);
        check("armed_abort_valid", av, 0);
        repeat (2) @(negedge clk);
        check("eaten_held", ec, 1);
        game = 2'b10;
        push_spawn();
        @(negedge clk);
        check("eaten_cleared", ec, 0);
        wait_valid(RMAX + 3);

        // eat, then leave PLAY during SPAWN: no new apple appears
        hx = ax; hy = ay;
        q_pulse.push_back('{7'd1, cyc + 1});
        @(negedge clk);
        game = 2'b00;
        repeat (3) @(negedge clk);
        check("spawn_abort_valid", av, 0);
        check("eaten_held_2", ec, 1);
        game = 2'b10;
        push_spawn();
        @(negedge clk);
        check("eaten_cleared_2", ec, 0);
        wait_valid(RMAX + 3);

        // reset mid-operation from ARMED
        rst = 1'b1;
        @(negedge clk);
        check("midreset_outs", {add, av, ap, ax, ay, ec}, 0);
        push_spawn();
        rst = 1'b0;
        wait_valid(RMAX + 3);

        repeat (2) @(negedge clk);
        check("apple_queue_drained", q_apple.size(), 0);
        check("pulse_queue_drained", q_pulse.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
